shift_merge_unit: RTL and testbench

- Execute-side consumer of the shift/merge decode outputs (sa, pl, pr) for EXTR, DEP and DSR.
- Takes decoded control plus operands and produces the result word.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Sits between the shift/merge decode logic and the writeback mux.

---
 rtl/shift_merge_unit_pkg.sv | 39 +++
 rtl/smu_funnel_shifter.sv | 24 ++
 rtl/shift_merge_unit.sv | 186 ++++++++++++++++++
 tb/tb_shift_merge_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_merge_unit_pkg.sv
// -----------------------------------------------------------------------------
// shift_merge_unit_pkg
// Shared definitions for the shift/merge execute unit and its decode checker:
//   - op_e       : operation encodings (EXTR, DEP, DSR, reserved)
//   - SMU_WIDTH  : default data word width
//   - SMU_SAW    : default width of the sa/pl/pr fields
//   - smu_mask() : field mask with ones at MSB-numbered positions pl..pr
// Bit numbering in this design family: position 0 is the MSB, position
// WIDTH-1 is the LSB. Position p lives at Verilog index WIDTH-1-p.
// -----------------------------------------------------------------------------
package shift_merge_unit_pkg;

    localparam int SMU_WIDTH = 24;
    localparam int SMU_SAW   = 5;

    typedef enum logic [1:0] {
        OP_EXTR = 2'd0,
        OP_DEP  = 2'd1,
        OP_DSR  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    // Ones at MSB-numbered positions pl..pr inclusive. An empty mask results
    // when pl > pr; callers flag that case as illegal separately.
    function automatic logic [SMU_WIDTH-1:0] smu_mask(
        input logic [SMU_SAW-1:0] pl,
        input logic [SMU_SAW-1:0] pr
    );
        logic [SMU_WIDTH-1:0] m;
        m = '0;
        for (int p = 0; p < SMU_WIDTH; p++) begin
            if (p >= int'(pl) && p <= int'(pr)) begin
                m[SMU_WIDTH-1-p] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/smu_funnel_shifter.sv
// -----------------------------------------------------------------------------
// smu_funnel_shifter
// Combinational funnel shifter: res_o = low WIDTH bits of ({hi_i, lo_i} >> amt_i).
// EXTR uses hi=0, lo=a; DEP uses hi=b, lo=0 with amt=WIDTH-sa (a left shift);
// DSR uses hi=a, lo=b directly.
// Ports:
//   hi_i  [WIDTH-1:0]  upper (MSB-side) word
//   lo_i  [WIDTH-1:0]  lower (LSB-side) word
//   amt_i [SHW-1:0]    right-shift amount, 0..2*WIDTH-1
//   res_o [WIDTH-1:0]  low word of the shifted concatenation
// -----------------------------------------------------------------------------
module smu_funnel_shifter #(
    parameter int WIDTH = 24,
    parameter int SHW   = 6
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [SHW-1:0]   amt_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = WIDTH'({hi_i, lo_i} >> amt_i);

endmodule

// File: rtl/shift_merge_unit.sv
// -----------------------------------------------------------------------------
// shift_merge_unit
// Execute-side shift/merge unit for EXTR, DEP and DSR. Two registered stages:
//   stage 1 (shift): funnel shift, field mask and merge base are computed and
//                    registered together with the illegal-request flag;
//   stage 2 (merge): out_data = (sh & mask) | (base & ~mask), or 0 if illegal.
// Ports:
//   clock, reset_n             clock (rising edge), async active-low reset
//   in_valid / in_ready        request handshake
//   in_op, in_sgn, in_zero     decoded operation and flags
//   in_sa, in_pl, in_pr        shift amount and field bounds (MSB-numbered)
//   in_a, in_b, in_c           operands
//   out_valid / out_ready      result handshake
//   out_data, out_err          result word and illegal-request flag
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both high; a valid beat and its payload stay put until taken, and
// ready never waits on valid of the same interface.
// -----------------------------------------------------------------------------
module shift_merge_unit
    import shift_merge_unit_pkg::*;
#(
    parameter int WIDTH = SMU_WIDTH,
    parameter int SAW   = SMU_SAW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_sgn,
    input  logic             in_zero,
    input  logic [SAW-1:0]   in_sa,
    input  logic [SAW-1:0]   in_pl,
    input  logic [SAW-1:0]   in_pr,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    localparam int           SHW  = $clog2(2 * WIDTH);
    localparam logic [SAW:0] WLIM = (SAW + 1)'(WIDTH);

    // Pipeline state
    logic             rdy_en_q;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_sh_q;
    logic [WIDTH-1:0] s1_mask_q;
    logic [WIDTH-1:0] s1_base_q;
    logic             s1_err_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_err_q;

    // Stage-1 next values
    logic [WIDTH-1:0] fs_hi;
    logic [WIDTH-1:0] fs_lo;
    logic [SHW-1:0]   fs_amt;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] base_d;
    logic             err_d;
    logic             sign_bit;

    // Stage-2 next value
    logic [WIDTH-1:0] merge_d;

    // Flow control
    logic s2_ready;
    logic s1_advance;
    logic accept;

    // Stage 2 can take a beat when empty or when its beat leaves this cycle.
    assign s2_ready   = !out_valid_q || out_ready;
    assign s1_advance = s2_ready;
    // rdy_en_q holds in_ready low until one cycle after reset release.
    assign in_ready   = rdy_en_q && (!s1_valid_q || s1_advance);
    assign accept     = in_valid && in_ready;

    // Operand routing into the shared funnel shifter.
    always_comb begin
        fs_hi  = '0;
        fs_lo  = in_a;
        fs_amt = SHW'(in_sa);
        case (in_op)
            OP_DEP: begin
                // b << sa expressed as {b,0} >> (WIDTH - sa)
                fs_hi  = in_b;
                fs_lo  = '0;
                fs_amt = SHW'(WIDTH) - SHW'(in_sa);
            end
            OP_DSR: begin
                fs_hi  = in_a;
                fs_lo  = in_b;
                fs_amt = SHW'(in_sa);
            end
            default: begin
                fs_hi  = '0;
                fs_lo  = in_a;
                fs_amt = SHW'(in_sa);
            end
        endcase
    end

    smu_funnel_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_funnel (
        .hi_i  (fs_hi),
        .lo_i  (fs_lo),
        .amt_i (fs_amt),
        .res_o (sh_d)
    );

    // Mask, merge base and legality for the incoming request.
    always_comb begin
        err_d = (in_op == OP_RSVD) || (in_pl > in_pr) ||
                ({1'b0, in_sa} >= WLIM) || ({1'b0, in_pl} >= WLIM) ||
                ({1'b0, in_pr} >= WLIM);

        mask_d = (in_op == OP_DSR) ? '1 : smu_mask(in_pl, in_pr);

        // Sign of an extracted field is its MSB-side bit, position pl.
        sign_bit = 1'b0;
        for (int p = 0; p < WIDTH; p++) begin
            if (p == int'(in_pl)) begin
                sign_bit = sh_d[WIDTH-1-p];
            end
        end

        base_d = '0;
        if (in_op == OP_EXTR && in_sgn) begin
            for (int p = 0; p < WIDTH; p++) begin
                if (p < int'(in_pl)) begin
                    base_d[WIDTH-1-p] = sign_bit;
                end
            end
        end else if (in_op == OP_DEP && !in_zero) begin
            base_d = in_c;
        end
    end

    assign merge_d = s1_err_q ? '0 : ((s1_sh_q & s1_mask_q) | (s1_base_q & ~s1_mask_q));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sh_q     <= '0;
            s1_mask_q   <= '0;
            s1_base_q   <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;

            if (s1_advance) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= merge_d;
                    out_err_q  <= s1_err_q;
                end
            end

            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_sh_q   <= sh_d;
                s1_mask_q <= mask_d;
                s1_base_q <= base_d;
                s1_err_q  <= err_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_merge_unit.sv
module tb_shift_merge_unit;

  localparam int W = 24;

  typedef struct {
    logic [1:0]   op;
    logic         sgn;
    logic         zero;
    logic [4:0]   sa;
    logic [4:0]   pl;
    logic [4:0]   pr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } beat_t;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic         in_sgn;
  logic         in_zero;
  logic [4:0]   in_sa;
  logic [4:0]   in_pl;
  logic [4:0]   in_pr;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int acc_cnt    = 0;
  bit rdy_rand   = 0;
  bit sends_done = 0;

  // Expected {err, data} per accepted beat, in order.
  logic [W:0] exp_q[$];

  shift_merge_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_sgn    (in_sgn),
    .in_zero   (in_zero),
    .in_sa     (in_sa),
    .in_pl     (in_pl),
    .in_pr     (in_pr),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from MSB-numbered positions: position p is Verilog bit W-1-p.
  function automatic logic [W:0] ref_model(input beat_t bt);
    logic [2*W-1:0] wide;
    logic [W-1:0]   sh;
    logic [W-1:0]   res;
    int             pl;
    int             pr;
    pl = int'(bt.pl);
    pr = int'(bt.pr);
    if (bt.op == 2'd3 || pl > pr || int'(bt.sa) >= W || pl >= W || pr >= W)
      return {1'b1, {W{1'b0}}};
    case (bt.op)
      2'd0:    sh = bt.a >> bt.sa;
      2'd1:    sh = bt.b << bt.sa;
      default: begin
        wide = {bt.a, bt.b} >> bt.sa;
        sh   = wide[W-1:0];
      end
    endcase
    res = '0;
    for (int p = 0; p < W; p++) begin
      if (bt.op == 2'd2 || (p >= pl && p <= pr))
        res[W-1-p] = sh[W-1-p];
      else if (bt.op == 2'd0)
        res[W-1-p] = (bt.sgn && p < pl) ? sh[W-1-pl] : 1'b0;
      else
        res[W-1-p] = bt.zero ? 1'b0 : bt.c[W-1-p];
    end
    return {1'b0, res};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_garbage();
    in_op   = 2'($urandom);
    in_sgn  = 1'($urandom);
    in_zero = 1'($urandom);
    in_sa   = 5'($urandom);
    in_pl   = 5'($urandom);
    in_pr   = 5'($urandom);
    in_a    = W'($urandom);
    in_b    = W'($urandom);
    in_c    = W'($urandom);
  endtask

  task automatic send(input beat_t bt);
    int waited = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_op    = bt.op;
    in_sgn   = bt.sgn;
    in_zero  = bt.zero;
    in_sa    = bt.sa;
    in_pl    = bt.pl;
    in_pr    = bt.pr;
    in_a     = bt.a;
    in_b     = bt.b;
    in_c     = bt.c;
    forever begin
      #2;
      if (in_ready) begin
        exp_q.push_back(ref_model(bt));
        acc_cnt++;
        @(posedge clock);
        break;
      end
      @(posedge clock);
      waited++;
      if (waited > 200) begin
        chk("send_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
      @(negedge clock);
    end
    #1;
    in_valid = 1'b0;
    drive_garbage();
  endtask

  function automatic beat_t mk(input logic [1:0] op, input logic sgn, input logic zero,
                               input logic [4:0] sa, input logic [4:0] pl, input logic [4:0] pr,
                               input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    beat_t bt;
    bt.op = op; bt.sgn = sgn; bt.zero = zero;
    bt.sa = sa; bt.pl = pl; bt.pr = pr;
    bt.a = a; bt.b = b; bt.c = c;
    return bt;
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    int    sel;
    sel     = $urandom_range(0, 19);
    bt.op   = (sel == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    bt.sgn  = 1'($urandom);
    bt.zero = 1'($urandom);
    bt.a    = W'($urandom);
    bt.b    = W'($urandom);
    bt.c    = W'($urandom);
    if (sel == 1) begin
      bt.sa = 5'($urandom);
      bt.pl = 5'($urandom);
      bt.pr = 5'($urandom);
    end else begin
      bt.sa = 5'($urandom_range(0, W - 1));
      bt.pl = 5'($urandom_range(0, W - 1));
      bt.pr = 5'($urandom_range(int'(bt.pl), W - 1));
    end
    return bt;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clock);
      n++;
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  // ---------------- out_ready generator ----------------
  always @(negedge clock) begin
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard / monitor ----------------
  logic       stall_prev = 1'b0;
  logic [W:0] prev_beat;
  always begin
    @(negedge clock);
    #3;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else if (out_valid) begin
      if (stall_prev) chk("stall_stable", {7'd0, out_err, out_data}, {7'd0, prev_beat});
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {31'd0, out_valid}, 32'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("result", {7'd0, out_err, out_data}, {7'd0, e});
        end
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        prev_beat  = {out_err, out_data};
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_garbage();

    // Reset state
    repeat (2) @(negedge clock);
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {8'd0, out_data}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #3;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // DSR with latency check
    out_ready = 1'b1;
    send(mk(2'd2, 1'b0, 1'b0, 5'd4, 5'd0, 5'd23, 24'h000001, 24'h000000, 24'h0));
    @(negedge clock);
    #3;
    chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    #3;
    chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    chk("dsr_data", {8'd0, out_data}, 32'h100000);
    chk("dsr_err", {31'd0, out_err}, 32'd0);

    // EXTR / DEP directed cases
    send(mk(2'd0, 1'b0, 1'b0, 5'd8,  5'd16, 5'd23, 24'hABCDEF, 24'h0, 24'h0));
    send(mk(2'd0, 1'b1, 1'b0, 5'd12, 5'd20, 5'd23, 24'h00F000, 24'h0, 24'h0));
    send(mk(2'd1, 1'b0, 1'b0, 5'd4,  5'd16, 5'd19, 24'h0, 24'h000005, 24'hFFFFFF));
    send(mk(2'd1, 1'b0, 1'b1, 5'd4,  5'd16, 5'd19, 24'h0, 24'h000005, 24'hFFFFFF));
    drain("drain_directed");

    // Back-to-back 4 beats with a 3-cycle output stall
    @(negedge clock);
    out_ready  = 1'b0;
    base       = acc_cnt;
    sends_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(rand_beat());
        sends_done = 1'b1;
      end
    join_none
    n = 0;
    while (acc_cnt < base + 2 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    @(negedge clock);
    #3;
    chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (2) @(negedge clock);
    @(negedge clock);
    out_ready = 1'b1;
    n = 0;
    while (!sends_done && n < 500) begin
      @(posedge clock);
      n++;
    end
    chk("stall_sends_done", {31'd0, sends_done}, 32'd1);
    chk("stall_all_accepted", acc_cnt - base, 32'd4);
    drain("drain_stall");

    // Illegal request followed by a legal one
    send(mk(2'd0, 1'b0, 1'b0, 5'd0, 5'd20, 5'd10, 24'h123456, 24'h0, 24'h0));
    send(mk(2'd0, 1'b0, 1'b0, 5'd0, 5'd0,  5'd23, 24'h123456, 24'h0, 24'h0));
    drain("drain_illegal");

    // Randomized traffic with random backpressure and idle gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rand_beat());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    rdy_rand = 1'b0;
    @(negedge clock);
    out_ready = 1'b1;
    drain("drain_random");

    // Reset with two beats in flight
    @(negedge clock);
    out_ready = 1'b0;
    send(rand_beat());
    send(rand_beat());
    @(negedge clock);
    #1;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clock);
      #3;
      chk("no_stale_beat", {31'd0, out_valid}, 32'd0);
    end

    // One more legal beat after reset to show the pipe still works
    send(mk(2'd1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd23, 24'h0, 24'h5A5A5A, 24'h0));
    drain("drain_post_reset");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
